// File: rtl/busy_monitor.sv
// busy_monitor: waits for the EPD BUSY pin to settle at its idle level and
// reports done, timeout or abort, with elapsed-cycle readback.
module busy_monitor #(
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILTER_LEN  = 4,
   parameter bit          BUSY_ACTIVE = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] min_cycles,
   input  logic [CNT_W-1:0] tmo_cycles,
   input  logic             epd_busy,
   output logic             busy,
   output logic             done,
   output logic             timeout,
   output logic             aborted,
   output logic [CNT_W-1:0] elapsed,
   output logic             pin_idle
);

   localparam logic                 IDLE_LVL = ~BUSY_ACTIVE;
   localparam int unsigned          FCNT_W   = $clog2(FILTER_LEN + 1);
   localparam logic [FCNT_W-1:0]    FMAX     = FCNT_W'(FILTER_LEN);

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_WAIT} state_t;

   state_t             state, state_nxt;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [FCNT_W-1:0]  fcnt, fcnt_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt, cnt_inc;
   logic [CNT_W-1:0]   min_lat, min_nxt, tmo_lat, tmo_nxt;
   logic [CNT_W-1:0]   elapsed_nxt;
   logic               busy_nxt, done_nxt, timeout_nxt, aborted_nxt;
   logic               synced;

   assign synced  = sync_q[SYNC_STAGES-1];
   assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

   always_comb begin
      fcnt_nxt = '0;
      if (synced == IDLE_LVL)
         fcnt_nxt = (fcnt == FMAX) ? fcnt : fcnt + 1'b1;
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      min_nxt     = min_lat;
      tmo_nxt     = tmo_lat;
      busy_nxt    = busy;
      elapsed_nxt = elapsed;
      done_nxt    = 1'b0;
      timeout_nxt = 1'b0;
      aborted_nxt = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_SETTLE;
               busy_nxt  = 1'b1;
               cnt_nxt   = '0;
               min_nxt   = min_cycles;
               tmo_nxt   = tmo_cycles;
            end
         end
         S_SETTLE: begin
            if (abort) begin
               state_nxt   = S_IDLE;
               busy_nxt    = 1'b0;
               elapsed_nxt = cnt;
               aborted_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt_inc;
               if (cnt >= min_lat)
                  state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            // Termination priority: abort, then done, then timeout.
            if (abort || pin_idle || (tmo_lat != '0 && cnt >= tmo_lat)) begin
               state_nxt   = S_IDLE;
               busy_nxt    = 1'b0;
               elapsed_nxt = cnt;
               aborted_nxt = abort;
               done_nxt    = !abort && pin_idle;
               timeout_nxt = !abort && !pin_idle;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         sync_q   <= {SYNC_STAGES{IDLE_LVL}};
         fcnt     <= '0;
         pin_idle <= 1'b0;
         cnt      <= '0;
         min_lat  <= '0;
         tmo_lat  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         timeout  <= 1'b0;
         aborted  <= 1'b0;
         elapsed  <= '0;
      end else begin
         state    <= state_nxt;
         sync_q   <= {sync_q[SYNC_STAGES-2:0], epd_busy};
         fcnt     <= fcnt_nxt;
         pin_idle <= (fcnt_nxt == FMAX);
         cnt      <= cnt_nxt;
         min_lat  <= min_nxt;
         tmo_lat  <= tmo_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
         timeout  <= timeout_nxt;
         aborted  <= aborted_nxt;
         elapsed  <= elapsed_nxt;
      end
   end

endmodule

// File: tb/tb_busy_monitor.sv
// Directed bench for busy_monitor: expected terminations are queued as each
// wait is launched and popped when a pulse appears.
module tb_busy_monitor;

   localparam int unsigned CNT_W = 32;
   localparam int K_DONE = 0, K_TMO = 1, K_ABORT = 2;

   typedef struct {
      int          kind;
      logic [31:0] lo;
      logic [31:0] hi;
      string       tag;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset, start, abort, epd_busy;
   logic [CNT_W-1:0] min_cycles, tmo_cycles;
   logic             busy, done, timeout, aborted, pin_idle;
   logic [CNT_W-1:0] elapsed;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   edges  = 0;
   int   npulse = 0;

   busy_monitor #(.CNT_W(CNT_W), .SYNC_STAGES(2), .FILTER_LEN(4), .BUSY_ACTIVE(1'b1)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .min_cycles(min_cycles), .tmo_cycles(tmo_cycles), .epd_busy(epd_busy),
      .busy(busy), .done(done), .timeout(timeout), .aborted(aborted),
      .elapsed(elapsed), .pin_idle(pin_idle)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (done || timeout || aborted) npulse++;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         edges++;
      end
   endtask

   // Launches a wait; on return the start edge (E0) has passed and edges==0.
   task automatic do_start(input logic [31:0] mn, input logic [31:0] tm);
      min_cycles = mn;
      tmo_cycles = tm;
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      edges = 0;
   endtask

   task automatic push(input int kind, input logic [31:0] lo, input logic [31:0] hi, input string tag);
      exp_t e;
      e.kind = kind; e.lo = lo; e.hi = hi; e.tag = tag;
      exp_q.push_back(e);
   endtask

   task automatic wait_pulse(input int max, output int n);
      exp_t e;
      int   kind;
      n = 0;
      while (n < max && !(done || timeout || aborted)) begin
         tick(1);
         n++;
      end
      if (!(done || timeout || aborted)) begin
         checks++;
         errors++;
         $error("FAIL pulse_wait: observed no pulse after %0d cycles expected a pulse", max);
         if (exp_q.size() > 0) void'(exp_q.pop_front());
         return;
      end
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL unexpected_pulse: observed pulse expected none");
         return;
      end
      e    = exp_q.pop_front();
      kind = done ? K_DONE : (timeout ? K_TMO : K_ABORT);
      chk({e.tag, "_kind"}, kind, e.kind);
      chk({e.tag, "_onehot"}, $countones({done, timeout, aborted}), 1);
      chk({e.tag, "_busy_low"}, busy, 0);
      chk({e.tag, "_elapsed"}, (elapsed >= e.lo && elapsed <= e.hi), 1);
      if (!(elapsed >= e.lo && elapsed <= e.hi))
         $error("FAIL %s_elapsed_value: observed %0d expected %0d..%0d", e.tag, elapsed, e.lo, e.hi);
   endtask

   initial begin
      int n, p0;
      reset = 1'b1; start = 1'b0; abort = 1'b0; epd_busy = 1'b0;
      min_cycles = '0; tmo_cycles = '0;
      tick(3);
      chk("rst_busy", busy, 0);
      chk("rst_pulses", {done, timeout, aborted}, 0);
      chk("rst_elapsed", elapsed, 0);
      chk("rst_pin_idle", pin_idle, 0);
      reset = 1'b0;
      tick(8);
      chk("idle_pin_idle", pin_idle, 1);

      // 1: pin already idle, min=0
      do_start(0, 100);
      push(K_DONE, 1, 1, "t1");
      chk("t1_busy_e0", busy, 1);
      wait_pulse(10, n);
      chk("t1_latency", n, 2);
      tick(1);
      chk("t1_pulse_1cyc", done, 0);

      // 2: pin falls 50 cycles after start
      epd_busy = 1'b1;
      tick(8);
      chk("t2_pin_busy", pin_idle, 0);
      do_start(20, 1000);
      tick(49);
      chk("t2_still_busy", busy, 1);
      epd_busy = 1'b0;
      push(K_DONE, 55, 57, "t2");
      wait_pulse(30, n);

      // 3: pin held busy -> timeout at 30
      epd_busy = 1'b1;
      tick(8);
      p0 = npulse;
      do_start(0, 30);
      push(K_TMO, 30, 30, "t3");
      wait_pulse(60, n);
      tick(5);
      chk("t3_single_pulse", npulse - p0, 1);

      // tmo <= min: timeout on first WAIT cycle
      do_start(5, 3);
      push(K_TMO, 6, 6, "tmo_le_min");
      wait_pulse(20, n);
      chk("tmo_le_min_latency", n, 7);

      // 4: 3-cycle glitch rejected, 4+ cycle idle accepted
      do_start(0, 0);
      tick(10);
      p0 = npulse;
      epd_busy = 1'b0;
      tick(3);
      epd_busy = 1'b1;
      tick(20);
      chk("t4_glitch_no_pulse", npulse - p0, 0);
      chk("t4_glitch_busy", busy, 1);
      epd_busy = 1'b0;
      push(K_DONE, 39, 41, "t4");
      wait_pulse(20, n);

      // abort in IDLE does nothing
      epd_busy = 1'b1;
      tick(8);
      p0 = npulse;
      abort = 1'b1;
      tick(2);
      abort = 1'b0;
      tick(1);
      chk("idle_abort_pulses", npulse - p0, 0);
      chk("idle_abort_busy", busy, 0);

      // 5: abort and pin_idle on the same edge -> aborted wins
      do_start(0, 0);
      tick(4);
      epd_busy = 1'b0;
      tick(6);
      chk("t5_pre_busy", busy, 1);
      abort = 1'b1;
      push(K_ABORT, 10, 10, "t5");
      wait_pulse(1, n);
      abort = 1'b0;
      chk("t5_latency", n, 1);

      // 6: reset mid-WAIT
      epd_busy = 1'b1;
      tick(8);
      do_start(0, 0);
      tick(10);
      p0 = npulse;
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      chk("t6_busy", busy, 0);
      chk("t6_elapsed", elapsed, 0);
      tick(4);
      chk("t6_no_pulse", npulse - p0, 0);
      epd_busy = 1'b0;
      tick(8);
      do_start(0, 100);
      push(K_DONE, 1, 1, "t6_restart");
      wait_pulse(10, n);
      chk("t6_restart_latency", n, 2);

      chk("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
